fft_stage_sequencer: RTL
========================

# fft_stage_sequencer

Responder to `Control_unit` in the 32-point FFT datapath. It decodes the stage request on `enable` and the mode on `SEL`, then issues the 16 butterfly address pairs and twiddle indices for one radix-2 stage, or the 32 load (bit-reversed) or unload (natural order) addresses. It delays write-back addresses through a latency-matched pipeline and returns a one-cycle `done` pulse. The request must then be released before the next one is accepted.

## Interface
- `LAT`, default 3: butterfly datapath latency in cycles, from `addr_a`/`addr_b` valid to result ready (legal 1..8).
- `clk_100`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  4  stage request. Binary code: 0 = none, 1..5 = stage 1..5, 6..15 illegal.
- `SEL`  in  2  mode: 00 butterfly stage, 01 load, 10 unload, 11 reserved.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `bf_valid`  out  1  `addr_a`/`addr_b`/`tw_idx` valid this cycle.
- `addr_a`  out  5  upper butterfly address, or the load/unload address.
- `addr_b`  out  5  lower butterfly address (0 in load/unload).
- `tw_idx`  out  4  twiddle exponent k of W32^k (0 in load/unload).
- `wb_en`  out  1  write-back strobe (stage mode only).
- `wb_addr_a`, `wb_addr_b`  out  5 each  `addr_a`/`addr_b` delayed by `LAT` cycles.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  registered; high while in IDLE with an illegal request present.

## Operation
- States:
  - IDLE → RUN → FLUSH → DONE → REL → IDLE.
  - Stage mode runs all states.
  - Load and unload skip FLUSH: RUN → DONE.
- Acceptance: only in IDLE, and only when `enable` is 1..5 and `SEL` is not 11. `enable` and `SEL` are latched on that edge and later changes are ignored until REL.
- Illegal requests: `enable` 6..15, or `SEL`=11 with a nonzero `enable`. The request is not accepted and `err`=1 the next cycle. `err` clears the cycle after the request becomes legal or zero.
- RUN uses a counter j.
  - Stage mode: j counts 0..15. With s = stage and h = 2^(s-1):
    - pos = j & (h-1)
    - group = j >> (s-1)
    - `addr_a` = group·2h + pos
    - `addr_b` = `addr_a` + h
    - `tw_idx` = pos << (5-s)
  - Load: j counts 0..31, `addr_a` = 5-bit bit-reverse of j.
  - Unload: j counts 0..31, `addr_a` = j.
- Write-back pipeline: a `LAT`-deep shift register carries {`bf_valid`, `addr_a`, `addr_b`}, gated to stage mode. Its output drives `wb_en`, `wb_addr_a` and `wb_addr_b`.
- FLUSH lasts until the pipeline is empty, i.e. the cycle of the last `wb_en`.
- DONE: lasts one cycle, `done`=1.
- REL: waits for `enable`==0, then goes to IDLE. This stops a held request from re-triggering.
- All arithmetic is unsigned 5-bit with no wrap: the maximum `addr_b` is 31.

## Timing
- Reset: asynchronous. All outputs and the pipeline go to 0 and the FSM goes to IDLE immediately, including mid-RUN or mid-FLUSH. No `done` is issued for an aborted request. After reset is released, a request that is still held is accepted as new.
- Cycle numbering: the accepting edge is cycle 0.
- Stage mode:
  - `bf_valid` is high in cycles 1..16, with j = cycle−1.
  - `wb_en` is high in cycles 1+`LAT`..16+`LAT`.
  - `done` is high in cycle 17+`LAT`.
  - `busy` is high from cycle 1 until IDLE is re-entered.
- Load/unload: `bf_valid` is high in cycles 1..32 and `done` in cycle 33. `wb_en` stays 0.
- REL exit: if `enable` is already 0 during DONE, the FSM is IDLE in the cycle after `done`. The earliest new acceptance is the edge after that.
- Continuity: `bf_valid` is never deasserted mid-run; the run has no stall input.

## Test plan
- Stage 3: `enable`=3, `SEL`=00, `LAT`=3.
  - At j=5: `addr_a`=9, `addr_b`=13, `tw_idx`=4.
  - At j=0: `addr_a`=0, `addr_b`=4, `tw_idx`=0.
  - Exactly 16 `bf_valid` cycles, `done` at cycle 20.
- Stage 1 and stage 5 sweeps:
  - Stage 1: pairs (2j, 2j+1) with `tw_idx`=0.
  - Stage 5: pairs (j, j+16) with `tw_idx`=j.
  - Checked against a reference model.
- Load: `SEL`=01, `enable`=1.
  - j=1 → `addr_a`=16; j=6 → 12; j=31 → 31.
  - 32 valid cycles, `wb_en` never asserted, `done` at cycle 33.
- Handshake: hold `enable`=2 for 40 cycles after `done`.
  - Exactly one `done`, `busy` stays high.
  - Drop `enable`: IDLE on the next cycle, then re-raising it starts a new run.
- Reset mid-run: assert `rst_n`=0 at cycle 8 of a stage run.
  - All outputs 0 immediately, no `done`.
  - Release with `enable`=4 held: a fresh stage-4 run starts at j=0.
- Illegal requests: `enable`=9, then `SEL`=11 with `enable`=2.
  - `err`=1, `busy`=0, no `bf_valid`.
  - Switching to `enable`=2, `SEL`=00 clears `err` and starts a run.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_stage_sequencer                                                        |
// | Address/twiddle sequencer for one radix-2 stage or load/unload of a 32-pt  |
// | FFT, with a latency-matched write-back address pipeline.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_stage_sequencer #(
  parameter int LAT = 3
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic [3:0] enable,
  input  logic [1:0] SEL,
  output logic       busy,
  output logic       bf_valid,
  output logic [4:0] addr_a,
  output logic [4:0] addr_b,
  output logic [3:0] tw_idx,
  output logic       wb_en,
  output logic [4:0] wb_addr_a,
  output logic [4:0] wb_addr_b,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  localparam logic [1:0] MODE_STAGE  = 2'd0;
  localparam logic [1:0] MODE_LOAD   = 2'd1;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam logic [4:0] C_LAT_M1 = 5'(LAT - 1);
  localparam int         PW       = 11;

  logic [2:0]    state_q, state_d;
  logic [4:0]    j_q, j_d;
  logic [2:0]    stage_q, stage_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          bf_valid_q, bf_valid_d;
  logic [4:0]    addr_a_q, addr_a_d;
  logic [4:0]    addr_b_q, addr_b_d;
  logic [3:0]    tw_idx_q, tw_idx_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [PW-1:0] pipe_q [LAT];
  logic [PW-1:0] pipe_d [LAT];

  logic       w_req_legal;
  logic       w_req_illegal;
  logic       w_run_last;
  logic [2:0] w_sm1;
  logic [4:0] w_h;
  logic [4:0] w_pos;
  logic [4:0] w_grp;
  logic [4:0] w_bfa;
  logic [4:0] w_bfb;
  logic [4:0] w_tw;

  assign w_req_legal   = (enable != 4'd0) && (enable <= 4'd5) && (SEL != MODE_RSVD);
  assign w_req_illegal = (enable > 4'd5) || ((SEL == MODE_RSVD) && (enable != 4'd0));
  assign w_run_last    = (mode_q == MODE_STAGE) ? (j_q == 5'd15) : (j_q == 5'd31);

  // Butterfly pair for stage s: split j into group and in-group position.
  assign w_sm1 = stage_q - 3'd1;
  assign w_h   = 5'd1 << w_sm1;
  assign w_pos = {1'b0, j_q[3:0]} & (w_h - 5'd1);
  assign w_grp = {1'b0, j_q[3:0]} >> w_sm1;
  assign w_bfa = (w_grp << stage_q) | w_pos;
  assign w_bfb = w_bfa + w_h;
  assign w_tw  = w_pos << (3'd5 - stage_q);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      j_q        <= 5'd0;
      stage_q    <= 3'd0;
      mode_q     <= MODE_STAGE;
      busy_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= 5'd0;
      addr_b_q   <= 5'd0;
      tw_idx_q   <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      stage_q    <= stage_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      bf_valid_q <= bf_valid_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_idx_q   <= tw_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // j doubles as the flush counter so FLUSH spans exactly LAT cycles.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (w_req_legal) begin
          state_d = S_RUN;
          j_d     = 5'd0;
          stage_d = enable[2:0];
          mode_d  = SEL;
        end
      end
      S_RUN: begin
        if (w_run_last) begin
          j_d     = 5'd0;
          state_d = (mode_q == MODE_STAGE) ? S_FLUSH : S_DONE;
        end else begin
          j_d = j_q + 5'd1;
        end
      end
      S_FLUSH: begin
        if (j_q == C_LAT_M1) begin
          j_d     = 5'd0;
          state_d = S_DONE;
        end else begin
          j_d = j_q + 5'd1;
        end
      end
      S_DONE:  state_d = S_REL;
      S_REL:   if (enable == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = (state_q != S_IDLE);
    bf_valid_d = (state_q == S_RUN);
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_IDLE) && w_req_illegal;
    addr_a_d   = 5'd0;
    addr_b_d   = 5'd0;
    tw_idx_d   = 4'd0;
    if (state_q == S_RUN) begin
      if (mode_q == MODE_STAGE) begin
        addr_a_d = w_bfa;
        addr_b_d = w_bfb;
        tw_idx_d = w_tw[3:0];
      end else if (mode_q == MODE_LOAD) begin
        addr_a_d = {j_q[0], j_q[1], j_q[2], j_q[3], j_q[4]};
      end else begin
        addr_a_d = j_q;
      end
    end
    pipe_d[0] = {bf_valid_q && (mode_q == MODE_STAGE), addr_a_q, addr_b_q};
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign busy      = busy_q;
  assign bf_valid  = bf_valid_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wb_en     = pipe_q[LAT-1][10];
  assign wb_addr_a = pipe_q[LAT-1][9:5];
  assign wb_addr_b = pipe_q[LAT-1][4:0];

endmodule
`default_nettype wire
